// File: rtl/uart_framer_pkg.sv
// rtl/uart_framer_pkg.sv - shared types and constants for the UART packet framer
package uart_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } framer_state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT_LOW
  } send_phase_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
  localparam int CHK_WIDTH = 8;

  function automatic int calc_len(int pkt_samples, int sample_width, int word_size);
    return pkt_samples * (sample_width / word_size);
  endfunction

endpackage

// File: rtl/uart_packet_framer_if.sv
// rtl/uart_packet_framer_if.sv - sample stream in, transmitter byte interface out
interface uart_packet_framer_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WORD_SIZE    = 8
);
  logic [SAMPLE_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [WORD_SIZE-1:0]    tx_data;
  logic                    tx_en;
  logic                    tx_ready;

  modport master (output s_data, s_valid, tx_ready, input s_ready, tx_data, tx_en);
  modport slave  (input s_data, s_valid, tx_ready, output s_ready, tx_data, tx_en);
endinterface

// File: rtl/framer_fifo.sv
// rtl/framer_fifo.sv - first-word-fall-through sync FIFO with registered full/empty/count
module framer_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_next;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 1'b1;
  end

  // Flags come from the next count so a pop frees space for the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
endmodule

// File: rtl/uart_packet_framer.sv
// rtl/uart_packet_framer.sv - frames buffered samples as SYNC/SEQ/LEN/payload/CHK bytes
module uart_packet_framer
  import uart_framer_pkg::*;
#(
  parameter int         WORD_SIZE    = 8,
  parameter int         SAMPLE_WIDTH = 16,
  parameter int         PKT_SAMPLES  = 4,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_packet_framer_if.slave  bus,
  output logic                 busy,
  output logic [7:0]           seq_num
);
  localparam int BYTES = SAMPLE_WIDTH / WORD_SIZE;
  localparam int LEN   = calc_len(PKT_SAMPLES, SAMPLE_WIDTH, WORD_SIZE);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int BCW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int SUBW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [AW:0]      PKT_CNT   = CW'(PKT_SAMPLES);
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(LEN - 1);
  localparam logic [SUBW-1:0]  LAST_SUB  = SUBW'(BYTES - 1);

  framer_state_e           r_state, w_state_next;
  send_phase_e             r_phase, w_phase_next;
  logic [BCW-1:0]          r_byte_cnt;
  logic [SUBW-1:0]         r_sub_cnt;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [CHK_WIDTH-1:0]    r_chk;
  logic [WORD_SIZE-1:0]    r_tx_data;
  logic                    r_tx_en;
  logic                    r_busy;
  logic [7:0]              r_seq;

  logic                    w_issue, w_done, w_first_sub, w_pop;
  logic [WORD_SIZE-1:0]    w_byte;
  logic [SAMPLE_WIDTH-1:0] w_fifo_data;
  logic                    w_fifo_full, w_fifo_empty;
  logic [AW:0]             w_fifo_count;

  framer_fifo #(.WIDTH(SAMPLE_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.s_valid),
    .i_data  (bus.s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= PH_ISSUE;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
    end
  end

  // Each byte: ISSUE on tx_ready=1, then WAIT_LOW until the transmitter drops tx_ready.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    if (r_state == ST_IDLE) begin
      w_phase_next = PH_ISSUE;
      if (w_fifo_count >= PKT_CNT) w_state_next = ST_SYNC;
    end else if (w_issue) begin
      w_phase_next = PH_WAIT_LOW;
    end else if (w_done) begin
      w_phase_next = PH_ISSUE;
      case (r_state)
        ST_SYNC:    w_state_next = ST_SEQ;
        ST_SEQ:     w_state_next = ST_LEN;
        ST_LEN:     w_state_next = ST_PAYLOAD;
        ST_PAYLOAD: w_state_next = (r_byte_cnt == LAST_BYTE) ? ST_CHK : ST_PAYLOAD;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_issue     = (r_state != ST_IDLE) && (r_phase == PH_ISSUE) && bus.tx_ready;
    w_done      = (r_state != ST_IDLE) && (r_phase == PH_WAIT_LOW) && !bus.tx_ready;
    w_first_sub = (r_sub_cnt == '0);
    w_pop       = w_issue && (r_state == ST_PAYLOAD) && w_first_sub && !w_fifo_empty;
    w_byte      = '0;
    case (r_state)
      ST_SYNC:    w_byte = WORD_SIZE'(SYNC_BYTE);
      ST_SEQ:     w_byte = WORD_SIZE'(r_seq);
      ST_LEN:     w_byte = WORD_SIZE'(LEN);
      ST_PAYLOAD: w_byte = w_first_sub ? w_fifo_data[SAMPLE_WIDTH-1 -: WORD_SIZE]
                                       : r_shift[SAMPLE_WIDTH-1 -: WORD_SIZE];
      ST_CHK:     w_byte = WORD_SIZE'(r_chk);
      default:    w_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_seq      <= '0;
      r_chk      <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_sub_cnt  <= '0;
    end else begin
      r_tx_en <= w_issue;
      if (w_issue) begin
        r_tx_data <= w_byte;
        case (r_state)
          ST_SYNC:                    r_chk <= '0;
          ST_SEQ, ST_LEN, ST_PAYLOAD: r_chk <= r_chk ^ CHK_WIDTH'(w_byte);
          default:                    r_chk <= r_chk;
        endcase
        if (r_state == ST_PAYLOAD)
          r_shift <= (w_first_sub ? w_fifo_data : r_shift) << WORD_SIZE;
      end
      if (w_done && r_state == ST_PAYLOAD) begin
        r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + 1'b1;
        r_sub_cnt  <= (r_sub_cnt == LAST_SUB) ? '0 : r_sub_cnt + 1'b1;
      end
      if (r_state == ST_IDLE && w_state_next == ST_SYNC) r_busy <= 1'b1;
      if (w_done && r_state == ST_CHK) begin
        r_busy <= 1'b0;
        r_seq  <= r_seq + 1'b1;
      end
    end
  end

  assign bus.s_ready = !w_fifo_full;
  assign bus.tx_data = r_tx_data;
  assign bus.tx_en   = r_tx_en;
  assign busy        = r_busy;
  assign seq_num     = r_seq;
endmodule

// File: tb/tb_uart_packet_framer.sv
// tb/tb_uart_packet_framer.sv - randomized self-checking bench for uart_packet_framer
module tb_uart_packet_framer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [7:0]  seq_num;
  int          n_checks = 0;
  int          n_fail = 0;
  int          tx_delay = 1;
  int          tx_cnt = 0;
  logic        prev_tx_en = 1'b0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] mdl_fifo[$];
  logic [7:0]  mdl_seq = 8'd0;

  always #5 clk = ~clk;

  uart_packet_framer_if bus();

  uart_packet_framer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .seq_num (seq_num)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter: takes the byte on tx_en, then stays not-ready for tx_delay cycles.
  always @(posedge clk) begin
    if (reset) begin
      bus.tx_ready <= 1'b1;
      tx_cnt <= 0;
    end else if (bus.tx_en === 1'b1) begin
      rx_q.push_back(bus.tx_data);
      bus.tx_ready <= 1'b0;
      tx_cnt <= tx_delay;
    end else if (tx_cnt == 1) begin
      bus.tx_ready <= 1'b1;
      tx_cnt <= 0;
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (bus.tx_en === 1'b1) begin
      check("tx_en_while_not_ready", bus.tx_ready, 1);
      check("tx_en_back_to_back", prev_tx_en, 0);
    end
    prev_tx_en <= bus.tx_en;
  end

  // Reference: every 4 accepted samples become one frame.
  function automatic void build_frames();
    logic [7:0]  x;
    logic [15:0] s;
    while (mdl_fifo.size() >= 4) begin
      exp_q.push_back(8'hAA);
      exp_q.push_back(mdl_seq);
      exp_q.push_back(8'd8);
      x = mdl_seq ^ 8'd8;
      for (int k = 0; k < 4; k++) begin
        s = mdl_fifo.pop_front();
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        x = x ^ s[15:8] ^ s[7:0];
      end
      exp_q.push_back(x);
      mdl_seq = mdl_seq + 8'd1;
    end
  endfunction

  task automatic push(input logic [15:0] d);
    int n = 0;
    while (bus.s_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_timeout", bus.s_ready, 1);
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    mdl_fifo.push_back(d);
    @(negedge clk);
    bus.s_valid = 1'b0;
    build_frames();
  endtask

  task automatic wait_frames(input int budget);
    int n = 0;
    while ((rx_q.size() < exp_q.size() || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", (rx_q.size() >= exp_q.size()) && (busy === 1'b0), 1);
  endtask

  task automatic compare_frames();
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check("frame_byte", rx_q.pop_front(), exp_q.pop_front());
    check("missing_bytes", exp_q.size(), 0);
    check("extra_bytes", rx_q.size(), 0);
    check("seq_num", seq_num, mdl_seq);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    mdl_fifo.delete();
    mdl_seq = 8'd0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gap;
    int n;
    int seen;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_en", bus.tx_en, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_seq", seq_num, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_count", dut.u_fifo.o_count, 0);
    reset = 1'b0;

    // Known vector with an always-idle transmitter
    tx_delay = 1;
    push(16'h1234); push(16'h5678); push(16'h9ABC); push(16'hDEF0);
    wait_frames(500);
    check("t1_first_byte", rx_q[0], 8'hAA);
    compare_frames();
    check("t1_seq", seq_num, 1);

    // Three samples are not enough; the fourth starts the frame
    do_reset();
    for (int i = 0; i < 3; i++) push(16'($urandom()));
    repeat (50) @(negedge clk);
    check("t2_no_tx", rx_q.size(), 0);
    check("t2_busy", busy, 0);
    push(16'($urandom()));
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.tx_en === 1'b1) seen = 1;
    end
    check("t2_sync_latency", seen, 1);
    wait_frames(500);
    compare_frames();

    // Slow transmitter, FIFO fills, two packets with one idle cycle between
    do_reset();
    tx_delay = 500;
    for (int i = 0; i < 8; i++) push(16'($urandom()));
    check("t3_s_ready_full", bus.s_ready, 0);
    check("t3_count_full", dut.u_fifo.o_count, 8);
    n = 0;
    while (busy !== 1'b0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    gap = 0;
    while (busy === 1'b0 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    check("t3_idle_gap", gap, 1);
    wait_frames(10000);
    compare_frames();

    // Random samples, random transmitter latency and push gaps
    for (int p = 0; p < 6; p++) begin
      tx_delay = $urandom_range(1, 6);
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push(16'($urandom()));
      end
      wait_frames(1000);
      compare_frames();
    end

    // Sequence number wrap
    do_reset();
    tx_delay = 1;
    for (int p = 0; p < 257; p++) begin
      for (int i = 0; i < 4; i++) push(16'h0000);
      wait_frames(400);
      if (p == 255) begin
        check("t5_seq_ff", rx_q[1], 8'hFF);
        check("t5_chk_f7", rx_q[11], 8'hF7);
      end
      if (p == 256) check("t5_seq_wrap", rx_q[1], 8'h00);
      compare_frames();
    end

    // Reset during the WAIT_LOW of payload byte 3
    tx_delay = 4;
    for (int i = 0; i < 4; i++) push(16'($urandom()));
    n = 0;
    while (rx_q.size() < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_payload3", rx_q.size(), 7);
    reset = 1'b1;
    @(negedge clk);
    check("t6_tx_en", bus.tx_en, 0);
    check("t6_count", dut.u_fifo.o_count, 0);
    check("t6_seq", seq_num, 0);
    check("t6_s_ready", bus.s_ready, 1);
    check("t6_busy", busy, 0);
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    mdl_fifo.delete();
    mdl_seq = 8'd0;
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.tx_en === 1'b1) n++;
    end
    check("t6_no_tx_after_reset", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
